// File: rtl/pipeline_exec_ctrl.sv
// pipeline_exec_ctrl: run/step/halt-drain sequencer for the MIPS pipeline; CYCLE_COUNTER_EN adds o_cycle_cnt
module pipeline_exec_ctrl #(
  parameter int DRAIN_CYCLES = 4
`ifdef CYCLE_COUNTER_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start_cont,
  input  logic i_start_step,
  input  logic i_halt_detected,
  input  logic i_pc_mux_ctrl,
  input  logic i_load_use_hazard,
  output logic o_pipe_en,
  output logic o_pc_en,
  output logic o_if_id_en,
  output logic o_if_id_flush,
  output logic o_id_ex_flush,
  output logic o_halted
`ifdef CYCLE_COUNTER_EN
  , output logic [CNT_W-1:0] o_cycle_cnt
`endif
);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
  state_t state;
  logic r_draining;
  logic [DW-1:0] r_drain_cnt;
  logic adv, halt_acc, drain_done;
  always_comb begin
    adv = state == RUN || state == STEP;
    halt_acc = adv && !r_draining && !i_pc_mux_ctrl && !i_load_use_hazard && i_halt_detected;
    drain_done = adv && r_draining && r_drain_cnt == DW'(DRAIN_CYCLES - 1);
    o_pipe_en = adv;
    o_pc_en = adv && !r_draining && (i_pc_mux_ctrl || (!i_load_use_hazard && !i_halt_detected));
    o_if_id_en = adv && (r_draining || i_pc_mux_ctrl || !i_load_use_hazard);
    o_if_id_flush = adv && (r_draining || i_pc_mux_ctrl || (!i_load_use_hazard && i_halt_detected));
    o_id_ex_flush = adv && !r_draining && (i_pc_mux_ctrl || i_load_use_hazard);
    o_halted = state == HALTED;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      r_draining <= 1'b0;
      r_drain_cnt <= '0;
`ifdef CYCLE_COUNTER_EN
      o_cycle_cnt <= '0;
`endif
    end else begin
      state <= state == IDLE ? (i_start_cont ? RUN : i_start_step ? STEP : IDLE)
             : (state == HALTED || drain_done) ? HALTED
             : state == RUN ? RUN : IDLE;
      if (halt_acc) begin
        r_draining <= 1'b1;
        r_drain_cnt <= '0;
      end else if (adv && r_draining) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end
`ifdef CYCLE_COUNTER_EN
      if (adv) o_cycle_cnt <= o_cycle_cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// tb_pipeline_exec_ctrl: directed and randomized checks against a mode/drain-countdown model
module tb_pipeline_exec_ctrl;
  localparam int DRAIN = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0, i_start_cont = 1'b0, i_start_step = 1'b0;
  logic i_halt_detected = 1'b0, i_pc_mux_ctrl = 1'b0, i_load_use_hazard = 1'b0;
  logic o_pipe_en, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_halted;
  int checks = 0, errors = 0;
  int m_mode = M_IDLE, m_drain_left = 0;
  logic [31:0] m_cycles = '0;
  logic [5:0] got, exp;
`ifdef CYCLE_COUNTER_EN
  logic [31:0] o_cycle_cnt, got_cnt, exp_cnt;
`endif

  pipeline_exec_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start_cont(i_start_cont), .i_start_step(i_start_step),
    .i_halt_detected(i_halt_detected), .i_pc_mux_ctrl(i_pc_mux_ctrl),
    .i_load_use_hazard(i_load_use_hazard), .o_pipe_en(o_pipe_en), .o_pc_en(o_pc_en),
    .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_halted(o_halted)
`ifdef CYCLE_COUNTER_EN
    , .o_cycle_cnt(o_cycle_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // expected {pipe_en, pc_en, if_id_en, if_id_flush, id_ex_flush, halted}
  function automatic logic [5:0] model_out(input logic h, input logic pm, input logic lu);
    if (m_mode != M_RUN && m_mode != M_STEP) return {5'b0, m_mode == M_HALT};
    if (m_drain_left > 0) return 6'b101100;
    if (pm) return 6'b111110;
    if (lu) return 6'b100010;
    if (h) return 6'b101100;
    return 6'b111000;
  endfunction

  task automatic model_step(input logic r, input logic sc, input logic ss, input logic h,
                            input logic pm, input logic lu);
    bit fin = 0;
    if (r) begin
      m_mode = M_IDLE; m_drain_left = 0; m_cycles = '0;
      return;
    end
    if (m_mode == M_RUN || m_mode == M_STEP) begin
      m_cycles = m_cycles + 1;
      if (m_drain_left > 0) begin
        m_drain_left = m_drain_left - 1;
        fin = m_drain_left == 0;
      end else if (!pm && !lu && h) m_drain_left = DRAIN;
    end
    case (m_mode)
      M_IDLE: m_mode = sc ? M_RUN : ss ? M_STEP : M_IDLE;
      M_RUN: m_mode = fin ? M_HALT : M_RUN;
      M_STEP: m_mode = fin ? M_HALT : M_IDLE;
      default: m_mode = M_HALT;
    endcase
  endtask

  // drive one cycle, capture outputs before the edge, then advance the model
  task automatic cyc(input logic r, input logic sc, input logic ss, input logic h,
                     input logic pm, input logic lu);
    @(negedge i_clk);
    i_rst = r; i_start_cont = sc; i_start_step = ss;
    i_halt_detected = h; i_pc_mux_ctrl = pm; i_load_use_hazard = lu;
    #1;
    got = {o_pipe_en, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_halted};
    exp = model_out(h, pm, lu);
`ifdef CYCLE_COUNTER_EN
    got_cnt = o_cycle_cnt; exp_cnt = m_cycles;
`endif
    model_step(r, sc, ss, h, pm, lu);
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (got !== 6'b0) begin errors++; $display("FAIL reset c%0d got=%b exp=000000", i, got); end
      checks++;
`ifdef CYCLE_COUNTER_EN
      if (got_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", got_cnt); end
      checks++;
`endif
    end
  endtask

  task automatic test_halt_drain;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      cyc(0, 0, 0, c == 3, 0, 0);
      if (got !== exp || o_pc_en !== (c <= 2) || o_if_id_flush !== (c >= 3 && c <= 7) || o_halted !== (c >= 8)) begin
        errors++; $display("FAIL halt_drain c%0d got=%b exp=%b", c, got, exp);
      end
      checks++;
`ifdef CYCLE_COUNTER_EN
      if (c >= 8 && got_cnt !== 32'd7) begin errors++; $display("FAIL halt_cnt got=%0d exp=7", got_cnt); end
      checks++;
`endif
    end
    cyc(0, 1, 1, 0, 0, 0);
    if (got !== 6'b000001) begin errors++; $display("FAIL halted_sticky got=%b exp=000001", got); end
    checks++;
  endtask

  task automatic test_branch_hazard;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1);
    if (got !== 6'b111110 || got !== exp) begin errors++; $display("FAIL branch_hz got=%b exp=111110", got); end
    checks++;
    cyc(0, 0, 0, 0, 0, 0);
    if (got !== 6'b111000 || got !== exp) begin errors++; $display("FAIL branch_next got=%b exp=111000", got); end
    checks++;
  endtask

  task automatic test_load_use;
    cyc(0, 0, 0, 1, 0, 1);
    if (got !== 6'b100010 || got !== exp) begin errors++; $display("FAIL load_use got=%b exp=100010", got); end
    checks++;
    cyc(0, 0, 0, 0, 0, 0);
    if (got !== 6'b111000 || got !== exp) begin errors++; $display("FAIL load_use_next got=%b exp=111000", got); end
    checks++;
  endtask

  task automatic test_step;
    int adv = 0;
    cyc(1, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      cyc(0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
        cyc(0, 0, 0, 0, 0, 0);
        adv += int'(o_pipe_en);
        if (got !== exp) begin errors++; $display("FAIL step p%0d k%0d got=%b exp=%b", p, k, got, exp); end
        checks++;
      end
    end
    if (adv !== 3) begin errors++; $display("FAIL step_adv got=%0d exp=3", adv); end
    checks++;
`ifdef CYCLE_COUNTER_EN
    cyc(0, 0, 0, 0, 0, 0);
    if (got_cnt !== 32'd3) begin errors++; $display("FAIL step_cnt got=%0d exp=3", got_cnt); end
    checks++;
`endif
  endtask

  task automatic test_step_halt_reset;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int s = 1; s <= 4; s++) begin
      cyc(0, 0, 1, 0, 0, 0);
      if (got !== 6'b000000) begin errors++; $display("FAIL step_halt_idle s%0d got=%b", s, got); end
      checks++;
      cyc(0, 0, 0, 0, 0, 0);
      if (got !== 6'b101100 || got !== exp) begin errors++; $display("FAIL step_drain s%0d got=%b exp=101100", s, got); end
      checks++;
    end
    cyc(0, 0, 0, 0, 0, 0);
    if (got !== 6'b000001 || got !== exp) begin errors++; $display("FAIL step_halted got=%b exp=000001", got); end
    checks++;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    if (got !== 6'b000000) begin errors++; $display("FAIL rst_drain_idle got=%b exp=000000", got); end
    checks++;
    cyc(0, 0, 0, 0, 0, 0);
    if (got !== 6'b111000 || got !== exp) begin errors++; $display("FAIL rst_drain_clear got=%b exp=111000", got); end
    checks++;
  endtask

  task automatic test_random;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
      if (got !== exp) begin errors++; $display("FAIL random i%0d got=%b exp=%b", i, got, exp); end
      checks++;
`ifdef CYCLE_COUNTER_EN
      if (got_cnt !== exp_cnt) begin errors++; $display("FAIL random_cnt i%0d got=%0d exp=%0d", i, got_cnt, exp_cnt); end
      checks++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_halt_drain();
    test_branch_hazard();
    test_load_use();
    test_step();
    test_step_halt_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
